// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter and run controller for the pipelined MIPS32 core.
// Shares one synchronous memory between fetch, data and loader ports.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpu_halted,
    output logic              cpu_run,
    output logic              cpu_stall,
    output logic [1:0]        state,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_BOOT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_IF   = 2'd1;
    localparam logic [1:0] O_DM   = 2'd2;
    localparam logic [1:0] O_LD   = 2'd3;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] starve_q;
    logic [2:0] starve_d;
    logic [1:0] owner_q;
    logic [1:0] owner_d;
    logic       halted_q;
    logic       halted_rise;
    logic       force_if;

    assign halted_rise = cpu_halted & ~halted_q;
    assign force_if    = (starve_q >= STARVE_LIM);

    // Grants depend only on registered state and live requests; gated by reset.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_BOOT, S_HALT: ld_gnt = ld_req;
                S_RUN: begin
                    if_gnt = if_req & (~dm_req | force_if);
                    dm_gnt = dm_req & ~if_gnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = if_gnt | dm_gnt | ld_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT, S_HALT: if (start) state_d = S_RUN;
            S_RUN:          if (halted_rise) state_d = S_DRAIN;
            S_DRAIN:        state_d = S_HALT;
            default:        state_d = S_BOOT;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt | ~if_req | (state_d != S_RUN))
            starve_d = '0;
        else if (dm_gnt)
            starve_d = starve_q + 3'd1;
    end

    always_comb begin
        owner_d = O_NONE;
        if (if_gnt)
            owner_d = O_IF;
        else if (dm_gnt & ~dm_we)
            owner_d = O_DM;
        else if (ld_gnt & ~ld_we)
            owner_d = O_LD;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            starve_q <= '0;
            owner_q  <= O_NONE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            halted_q <= cpu_halted;
        end
    end

    assign state     = state_q;
    assign cpu_run   = (state_q == S_RUN);
    assign cpu_stall = if_req & ~if_gnt & cpu_run;

    // Read data is broadcast; the owner tag alone selects who sees rvalid.
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign ld_rdata  = mem_rdata;
    assign if_rvalid = (owner_q == O_IF);
    assign dm_rvalid = (owner_q == O_DM);
    assign ld_rvalid = (owner_q == O_LD);

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter and run controller for the pipelined MIPS32 core. It shares one synchronous 32-bit memory between three requesters:

- the core's instruction-fetch port;
- the core's data (LW/SW) port;
- an external loader/debug port.

It also sequences the core through boot-load, run, drain and halted phases, so programs and data are loaded, and results read back, through real bus cycles.

## Interface

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W words)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced ahead of data

Ports:
- clk1  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin/restart execution
- cpu_halted  in  1  level from core, high once HLT retires
- cpu_run  out  1  core enable
- cpu_stall  out  1  fetch requested but not granted this cycle
- state  out  2  00 BOOT, 01 RUN, 10 DRAIN, 11 HALT
- if_req, if_addr[ADDR_W], if_gnt, if_rdata[DATA_W], if_rvalid  (in, in, out, out, out): fetch port
- dm_req, dm_we, dm_addr[ADDR_W], dm_wdata[DATA_W]  in: data request
- dm_gnt, dm_rdata[DATA_W], dm_rvalid  out: data response
- ld_req, ld_we, ld_addr[ADDR_W], ld_wdata[DATA_W]  in: loader request
- ld_gnt, ld_rdata[DATA_W], ld_rvalid  out: loader response
- mem_en, mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]  out: memory request
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en & ~mem_we

## Operation

Grants:
- Grants are combinational from the registered state and the current requests. At most one gnt is high per cycle.
- mem_* is muxed from the granted requester. mem_en = OR of gnts.
- All gnts are 0 while rst_n is low.

FSM:
- BOOT: only the loader is served (ld_gnt = ld_req); if_gnt = dm_gnt = 0. start -> RUN.
- RUN: loader blocked (ld_gnt = 0). dm beats if, except when the starvation counter reaches STARVE_MAX; then if wins that one cycle. A rising cpu_halted (registered edge detect) -> DRAIN.
- DRAIN: no new grants. Stays exactly one cycle so any outstanding read returns, then -> HALT.
- HALT: loader served as in BOOT. start -> RUN.
- start in RUN or DRAIN is ignored. cpu_halted in BOOT or HALT is ignored.

Outputs:
- cpu_run = 1 in RUN only.
- cpu_stall = if_req & ~if_gnt & cpu_run.

Starvation counter (3 bits):
- Increments when if_req & dm_gnt.
- Clears on if_gnt, on any cycle without if_req, and on leaving RUN.

Read return:
- A registered 2-bit owner tag records the granted reader (none, if, dm, ld); writes record none.
- The next cycle, the matching *_rvalid pulses for one cycle and *_rdata = mem_rdata.
- All rdata buses carry mem_rdata unconditionally; only rvalid qualifies them.
- Writes produce no rvalid.

Addresses are ADDR_W bits and wrap modulo 2^ADDR_W; there is no range check.

## Timing

- Reset values: state = BOOT, cpu_run = 0, cpu_stall = 0, all rvalid = 0, owner tag = none, starvation counter = 0, halted edge register = 0.
- Grant latency: 0 cycles (same-cycle gnt).
- Read data latency: 1 cycle after grant; back-to-back reads sustain one per cycle.
- Write completes in the grant cycle.
- start and ld_req in the same BOOT cycle: the loader access is granted that cycle; RUN begins the next cycle.
- cpu_halted rising in the same cycle as dm_req: dm is granted (the final SW completes), then DRAIN.
- A read granted in the last RUN cycle returns its rvalid during DRAIN.
- Reset asserted mid-transfer: all outputs take reset values immediately. A pending rvalid is dropped. The memory write in progress is not guaranteed.

## Test plan

- **Boot load.** Loader writes Mem[0..7] with the 8-instruction sequence (ADDI R1,R0,120 / dummy OR / LW / dummy OR / ADDI R2,R2,45 / dummy OR / SW R2,1(R1) / HLT) and Mem[120] = 85, then reads Mem[120].
  - Required: ld_gnt = 1 on each request; ld_rvalid one cycle after the read with ld_rdata = 85.
  - Required: if_gnt = dm_gnt = 0 throughout.
- **Run and halt.** Pulse start, run the core to HLT.
  - Required: state 01, then 10 for one cycle, then 11; cpu_run = 0 afterwards.
  - Required: a loader read of Mem[121] returns 130.
- **Contention.** In RUN, hold if_req and dm_req (dm_we = 0) high continuously.
  - Required: grant pattern dm, dm, dm, dm, if, repeating.
  - Required: cpu_stall high on the dm-granted cycles; each rvalid goes to the correct port one cycle later.
- **Loader lockout.** ld_req = 1 throughout RUN.
  - Required: ld_gnt = 0 until state = 11, then ld_gnt = 1.
- **Simultaneous events.** start with ld_req in BOOT; cpu_halted rising with a dm write in RUN; start during RUN.
  - Required: loader granted before RUN; the write lands in memory; the start during RUN causes no state change.
- **Reset mid-read.** Drop rst_n in the cycle after an if read grant.
  - Required: if_rvalid = 0, state = 00, cpu_run = 0 immediately.
  - Required: normal operation after rst_n rises and start is pulsed.
